seq_detect_prog: RTL and testbench

- Programmable serial bit-sequence detector, Moore-style with registered output.
- Generalised successor to the fixed 6-bit sequence FSM. Pattern and length (1..MAX_LEN) are loaded at run time; overlap mode is selectable; input is qualified by a valid strobe.
- Sits on the serial-input path in front of framing/sync logic; z flags a completed pattern.

---
 rtl/seq_detect_pkg.sv | 25 ++
 rtl/seq_detect_hist.sv | 44 ++++
 rtl/seq_detect_prog.sv | 82 ++++++++
 tb/tb_seq_detect_prog.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Holds the width calculation, reset defaults, length clamp and mask generator.
package seq_detect_pkg;

  localparam int MASK_W = 64;

  localparam logic [7:0] DEF_PAT = 8'b0011_0011;
  localparam int         DEF_LEN = 6;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  // Low-n ones; callers truncate to their own pattern width.
  function automatic logic [MASK_W-1:0] low_mask(input int unsigned n);
    if (n >= MASK_W) return '1;
    return (MASK_W'(1) << n) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/seq_detect_hist.sv
// Serial history shift register plus saturating fill counter.
// Exports next-state values so the match can be judged on post-update history.
module seq_detect_hist
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int FILL_W  = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               clear,
  input  logic               restart,
  output logic [MAX_LEN-1:0] hist,
  output logic [FILL_W-1:0]  fill,
  output logic [MAX_LEN-1:0] hist_nxt,
  output logic [FILL_W-1:0]  fill_nxt
);

  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    if (x_valid) begin
      hist_nxt = {hist[MAX_LEN-2:0], x};
      if (fill != FILL_W'(MAX_LEN)) fill_nxt = fill + FILL_W'(1);
    end
  end

  // restart drops fill only; the bits stay so a later overlap switch sees real data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_nxt;
      fill <= restart ? '0 : fill_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector, Moore style with registered z.
// Define SEQ_DETECT_MATCH_CNT_EN to build the saturating match counter.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(DEF_PAT),
  parameter int                 DEFAULT_LEN = DEF_LEN,
  parameter int                 CNT_W       = 8,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap_en,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pat_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [MAX_LEN-1:0] hist, hist_nxt, mask;
  logic [LEN_W-1:0]   fill, fill_nxt;
  logic               match, hit, restart;

  seq_detect_hist #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_hist (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
    .x_valid  (x_valid),
    .clear    (cfg_load),
    .restart  (restart),
    .hist     (hist),
    .fill     (fill),
    .hist_nxt (hist_nxt),
    .fill_nxt (fill_nxt)
  );

  always_comb begin
    mask    = MAX_LEN'(low_mask(32'(len_reg)));
    match   = (len_reg != '0) && (fill_nxt >= len_reg) &&
              (((hist_nxt ^ pat_reg) & mask) == '0);
    // a bit arriving with cfg_load is discarded, so it can never complete a match
    hit     = match && x_valid && !cfg_load;
    restart = hit && !overlap_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_reg <= DEFAULT_PAT;
      len_reg <= LEN_W'(DEFAULT_LEN);
      z       <= 1'b0;
    end else if (cfg_load) begin
      pat_reg <= pattern_in;
      len_reg <= LEN_W'(clamp_len(32'(len_in), MAX_LEN));
      z       <= 1'b0;
    end else begin
      z       <= hit;
    end
  end

`ifdef SEQ_DETECT_MATCH_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          match_count <= '0;
    else if (cnt_clr)                   match_count <= '0;
    else if (hit && match_count != '1)  match_count <= match_count + CNT_W'(1);
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: driver queues hand-computed z per cycle,
// monitor pops and compares one cycle later.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       x, x_valid, cfg_load, overlap_en, cnt_clr;
  logic [7:0] pattern_in;
  logic [3:0] len_in;
  logic       z;
  logic [7:0] match_count;

  typedef struct {
    logic       z;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] exp_cnt;
  int         total = 0;
  int         bad   = 0;
  string      cur   = "init";

  seq_detect_prog dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .pattern_in  (pattern_in),
    .len_in      (len_in),
    .overlap_en  (overlap_en),
    .cnt_clr     (cnt_clr),
    .z           (z),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_z"},   32'(z),           32'(e.z));
      chk({e.tag, "_cnt"}, 32'(match_count), 32'(e.cnt));
    end
  end

  task automatic cyc(input logic xi, input logic xv, input logic cl,
                     input logic cc, input logic ez);
    exp_t t;
    @(negedge clk);
    x = xi; x_valid = xv; cfg_load = cl; cnt_clr = cc;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    if (cc)                        exp_cnt = 8'd0;
    else if (ez && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`else
    exp_cnt = 8'd0;
`endif
    t.z = ez; t.cnt = exp_cnt; t.tag = cur;
    sb.push_back(t);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic xi, input logic xv);
    pattern_in = p; len_in = l;
    cyc(xi, xv, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run(input string bits, input string ez);
    for (int i = 0; i < bits.len(); i++)
      cyc(bits[i] == 8'h31, 1'b1, 1'b0, 1'b0, ez[i] == 8'h31);
  endtask

  initial begin
    reset = 1'b1; x = 0; x_valid = 0; cfg_load = 0; overlap_en = 1;
    cnt_clr = 0; pattern_in = 0; len_in = 0; exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_z",   32'(z),           32'd0);
    chk("reset_cnt", 32'(match_count), 32'd0);
    reset = 1'b0;

    cur = "dflt";     run("110011", "000001");
    cur = "ovl_on";   cfg(8'h33, 4'd6, 0, 0); overlap_en = 1;
                      run("1100110011", "0000010001");
    cur = "ovl_off";  cfg(8'h33, 4'd6, 0, 0); overlap_en = 0;
                      run("1100110011", "0000010000");
    cur = "p101_on";  cfg(8'h05, 4'd3, 0, 0); overlap_en = 1; run("10101", "00101");
    cur = "p101_off"; cfg(8'h05, 4'd3, 0, 0); overlap_en = 0; run("10101", "00100");

    cur = "gaps"; cfg(8'h33, 4'd6, 0, 0); overlap_en = 1;
    begin
      string b = "110011";
      for (int i = 0; i < 6; i++) begin
        cyc(b[i] == 8'h31, 1'b1, 1'b0, 1'b0, i == 5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    cur = "len0";  cfg(8'h00, 4'd0, 0, 0); run("000000111111", "000000000000");
    cur = "len15"; cfg(8'hB3, 4'd15, 0, 0); run("10110011", "00000001");
    cur = "cfg_xv"; cfg(8'h33, 4'd6, 1, 1); run("10011", "00000");

    // reset right after a z pulse; pattern must revert to the default
    cur = "rst_mid"; cfg(8'h05, 4'd3, 0, 0); run("101", "001");
    @(posedge clk); #2;
    reset = 1'b1; exp_cnt = 8'd0;
    #1;
    chk("midrst_z",   32'(z),           32'd0);
    chk("midrst_cnt", 32'(match_count), 32'd0);
    @(negedge clk); reset = 1'b0;
    cur = "post_rst"; run("110011", "000001");

    cur = "sat"; cfg(8'h01, 4'd1, 0, 0); overlap_en = 1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cur = "clr_hit"; cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cur = "after_clr"; cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
